// File: rtl/muldiv_unit.sv
// muldiv_unit: 33-cycle MULT/MULTU/DIV/DIVU engine with HI/LO and MTHI/MTLO.
// Ports: clk, rst (async high); start/op/busA/busB launch an op;
//   WEhi/WElo write HI/LO from busA when idle; HI/LO results;
//   busy while running; done/div0 one-cycle completion pulses.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  input  logic        WEhi,
  input  logic        WElo,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] a_raw;
  logic        sa;
  logic        sx;
  logic [4:0]  count;
  logic [63:0] p;

  logic        accept;
  logic        is_div;
  logic        sgn;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] add33;
  logic [63:0] mul_next;
  logic [32:0] sh;
  logic        ge;
  logic [31:0] sub;
  logic [63:0] div_next;
  logic [63:0] neg64;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign busy   = (state != IDLE);
  assign accept = (state == IDLE) && start;
  assign is_div = op_q[1];
  assign sgn    = op[0];
  assign a_abs  = (sgn && busA[31]) ? -busA : busA;
  assign b_abs  = (sgn && busB[31]) ? -busB : busB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (count == 5'd31) state_n = FIX;
      FIX:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Multiply: low half holds the shrinking multiplier, high half
  // accumulates; each step adds then shifts the 64-bit pair right.
  always_comb begin
    add33    = {1'b0, p[63:32]} + (p[0] ? {1'b0, a_q} : 33'd0);
    mul_next = {add33, p[31:1]};
  end

  // Divide: high half is the partial remainder, low half shifts
  // dividend bits out and quotient bits in. The shifted remainder
  // needs 33 bits; any successful subtract fits back in 32.
  always_comb begin
    sh       = {p[63:32], p[31]};
    ge       = (sh >= {1'b0, b_q});
    sub      = sh[31:0] - b_q;
    div_next = ge ? {sub, p[30:0], 1'b1}
                  : {sh[31:0], p[30:0], 1'b0};
  end

  always_comb begin
    neg64  = -p;
    res_hi = p[63:32];
    res_lo = p[31:0];
    if (!is_div) begin
      if (sx) begin
        res_hi = neg64[63:32];
        res_lo = neg64[31:0];
      end
    end else if (b_q == 32'd0) begin
      res_hi = a_raw;
      res_lo = 32'hFFFF_FFFF;
    end else begin
      if (sx) res_lo = -p[31:0];
      if (sa) res_hi = -p[63:32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= 2'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      a_raw <= 32'd0;
      sa    <= 1'b0;
      sx    <= 1'b0;
      count <= 5'd0;
      p     <= 64'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      done  <= 1'b0;
      div0  <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op;
            a_q   <= a_abs;
            b_q   <= b_abs;
            a_raw <= busA;
            sa    <= sgn & busA[31];
            sx    <= sgn & (busA[31] ^ busB[31]);
            count <= 5'd0;
            p     <= {32'd0, op[1] ? a_abs : b_abs};
          end else begin
            if (WEhi) HI <= busA;
            if (WElo) LO <= busA;
          end
        end
        CALC: begin
          count <= count + 5'd1;
          p     <= is_div ? div_next : mul_next;
        end
        FIX: begin
          HI   <= res_hi;
          LO   <= res_lo;
          done <= 1'b1;
          div0 <= is_div && (b_q == 32'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: random and directed ops against an arithmetic model.
// Checks latency, HI/LO hold, MTHI/MTLO, busy-ignore and async reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] busA = 32'd0;
  logic [31:0] busB = 32'd0;
  logic        WEhi = 1'b0;
  logic        WElo = 1'b0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        div0;

  int vecs = 0;
  int errs = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .busA(busA), .busB(busB), .WEhi(WEhi), .WElo(WElo),
    .HI(HI), .LO(LO), .busy(busy), .done(done), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {div0, HI, LO} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint x;
    longint y;
    longint pr;
    int q;
    int r;
    logic [63:0] up;
    if (o == 2'd0) begin
      up = {32'd0, a} * {32'd0, b};
      return {1'b0, up};
    end
    if (o == 2'd1) begin
      x  = $signed(a);
      y  = $signed(b);
      pr = x * y;
      return {1'b0, 64'(pr)};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    if (o == 2'd2) return {1'b0, a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {1'b0, 32'd0, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    r = $signed(a) % $signed(b);
    return {1'b0, 32'(r), 32'(q)};
  endfunction

  task automatic drive_start(input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b);
    op    = o;
    busA  = a;
    busB  = b;
    start = 1'b1;
  endtask

  task automatic accept();
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 2'($urandom);
    busA  = $urandom;
    busB  = $urandom;
    chk("busy_at_accept", {63'd0, busy}, 64'd1);
  endtask

  task automatic launch(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    @(negedge clk);
    drive_start(o, a, b);
    accept();
  endtask

  task automatic finish_op(input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int n0,
                           input logic [31:0] old_hi,
                           input logic [31:0] old_lo);
    logic [64:0] exp;
    int n;
    bit drop;
    exp  = model(o, a, b);
    n    = n0;
    drop = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done !== 1'b1 && busy !== 1'b1) drop = 1'b1;
      if (n == 16) begin
        chk("hold_hi", {32'd0, HI}, {32'd0, old_hi});
        chk("hold_lo", {32'd0, LO}, {32'd0, old_lo});
      end
    end
    chk("latency", 64'(n), 64'd33);
    chk("busy_gap", {63'd0, drop}, 64'd0);
    chk("hi", {32'd0, HI}, {32'd0, exp[63:32]});
    chk("lo", {32'd0, LO}, {32'd0, exp[31:0]});
    chk("div0", {63'd0, div0}, {63'd0, exp[64]});
    chk("busy_at_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] oh;
    logic [31:0] ol;
    oh = HI;
    ol = LO;
    launch(o, a, b);
    finish_op(o, a, b, 0, oh, ol);
    @(posedge clk);
    #1;
    chk("done_clear", {63'd0, done}, 64'd0);
    chk("div0_clear", {63'd0, div0}, 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] oh;
    logic [31:0] ol;
    bit seen;

    #2 rst = 1'b1;
    #1;
    chk("rst_hi", {32'd0, HI}, 64'd0);
    chk("rst_lo", {32'd0, LO}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_div0", {63'd0, div0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'd1, 32'hFFFF_FFFD, 32'h0000_0007);
    chk("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000);
    chk("mult_min", {HI, LO}, 64'h4000_0000_0000_0000);
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(2'd2, 32'd100, 32'd7);
    chk("divu_100_7", {HI, LO}, {32'd2, 32'd14});
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);
    run_op(2'd2, 32'h64, 32'd0);
    chk("divu_zero", {HI, LO}, 64'h0000_0064_FFFF_FFFF);

    // start/MTHI/MTLO while busy are ignored; then back-to-back start.
    oh = HI;
    ol = LO;
    launch(2'd0, 32'd5, 32'd6);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    drive_start(2'd3, 32'hDEAD_BEEF, 32'd1);
    WEhi = 1'b1;
    WElo = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    WEhi  = 1'b0;
    WElo  = 1'b0;
    chk("busy_ignore", {63'd0, busy}, 64'd1);
    finish_op(2'd0, 32'd5, 32'd6, 10, oh, ol);
    chk("ignore_res", {HI, LO}, {32'd0, 32'd30});
    drive_start(2'd2, 32'd1000, 32'd9);
    accept();
    chk("b2b_done_clear", {63'd0, done}, 64'd0);
    finish_op(2'd2, 32'd1000, 32'd9, 0, 32'd0, 32'd30);
    @(posedge clk);
    #1;
    chk("b2b_done_clear2", {63'd0, done}, 64'd0);

    // Async reset mid-divide.
    launch(2'd2, 32'h1000, 32'd3);
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_hi", {32'd0, HI}, 64'd0);
    chk("mid_rst_lo", {32'd0, LO}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("no_done_after_rst", {63'd0, seen}, 64'd0);

    @(negedge clk);
    busA = 32'h1234_5678;
    WElo = 1'b1;
    @(posedge clk);
    #1;
    WElo = 1'b0;
    chk("mtlo_lo", {32'd0, LO}, 64'h1234_5678);
    chk("mtlo_hi", {32'd0, HI}, 64'd0);
    @(negedge clk);
    busA = 32'hCAFE_F00D;
    WEhi = 1'b1;
    WElo = 1'b1;
    @(posedge clk);
    #1;
    WEhi = 1'b0;
    WElo = 1'b0;
    chk("mt_both", {HI, LO}, 64'hCAFE_F00D_CAFE_F00D);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
